// File: rtl/aes_buf_pkg.sv
// aes_block_buffer shared types, constants and byte-swap helper.
// Byte-swap path is enabled by AES_BUF_BSWAP_EN in the top level.
package aes_buf_pkg;

  localparam int NWORDS = 4;
  localparam int WORD_W = 32;
  localparam int BLK_W  = 128;

  typedef enum logic [1:0] {
    R_EMPTY,
    R_FILL,
    R_FULL
  } rx_state_t;

  typedef enum logic {
    T_EMPTY,
    T_DRAIN
  } tx_state_t;

  function automatic logic [WORD_W-1:0] bswap32(
    input logic [WORD_W-1:0] w
  );
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_word_packer.sv
// 4x32 register file: indexed word write or full block load,
// indexed word read and whole-block view (slot0 in the MSBs).
module aes_word_packer
  import aes_buf_pkg::*;
(
  input  logic              hclk,
  input  logic              hrst,
  input  logic              i_wr_en,
  input  logic [1:0]        i_wr_idx,
  input  logic [WORD_W-1:0] i_wr_word,
  input  logic              i_ld_en,
  input  logic [BLK_W-1:0]  i_ld_blk,
  input  logic [1:0]        i_rd_idx,
  output logic [WORD_W-1:0] o_rd_word,
  output logic [BLK_W-1:0]  o_blk
);

  logic [WORD_W-1:0] r_slot [NWORDS];

  always_ff @(posedge hclk or negedge hrst) begin
    if (!hrst) begin
      for (int i = 0; i < NWORDS; i++)
        r_slot[i] <= '0;
    end else if (i_ld_en) begin
      for (int i = 0; i < NWORDS; i++)
        r_slot[i] <= i_ld_blk[BLK_W-1-WORD_W*i -: WORD_W];
    end else if (i_wr_en) begin
      r_slot[i_wr_idx] <= i_wr_word;
    end
  end

  assign o_rd_word = r_slot[i_rd_idx];
  assign o_blk     = {r_slot[0], r_slot[1],
                      r_slot[2], r_slot[3]};

endmodule

// File: rtl/aes_block_buffer.sv
// AHB <-> AES staging buffer: RX word packer, TX word unpacker,
// master mode/enable. AES_BUF_BSWAP_EN byte-reverses words.
module aes_block_buffer #(
  parameter int NWORDS = 4,
  parameter int DW     = 32
) (
  input  logic                 hclk,
  input  logic                 hrst,
  input  logic                 flush,
  input  logic [DW-1:0]        rx_word,
  input  logic                 rx_shift_en,
  output logic [NWORDS*DW-1:0] blk_data,
  output logic                 blk_valid,
  input  logic                 blk_ready,
  input  logic [NWORDS*DW-1:0] res_data,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic                 tx_shift_en,
  output logic [DW-1:0]        tx_word,
  output logic                 ahb_mode,
  output logic                 ahb_enable,
  output logic [2:0]           rx_cnt,
  output logic [2:0]           tx_cnt,
  output logic                 overflow,
  output logic                 underflow
);
  import aes_buf_pkg::*;

  rx_state_t   r_rx_st, w_rx_st_nx;
  tx_state_t   r_tx_st, w_tx_st_nx;
  logic [2:0]  r_rx_cnt, w_rx_cnt_nx;
  logic [2:0]  r_tx_cnt, w_tx_cnt_nx;
  logic        r_ovf, w_ovf_nx;
  logic        r_udf, w_udf_nx;
  logic        r_blk_valid, r_res_ready;
  logic        r_ahb_mode, r_ahb_en;

  logic        w_hs, w_rx_we, w_tx_ld;
  logic [1:0]  w_rx_idx, w_rd_idx;
  logic [DW-1:0] w_rx_in, w_tx_raw, w_tx_out;

`ifdef AES_BUF_BSWAP_EN
  assign w_rx_in  = bswap32(rx_word);
  assign w_tx_out = bswap32(w_tx_raw);
`else
  assign w_rx_in  = rx_word;
  assign w_tx_out = w_tx_raw;
`endif

  assign w_hs = r_blk_valid & blk_ready;

  always_comb begin
    w_rx_st_nx  = r_rx_st;
    w_rx_cnt_nx = r_rx_cnt;
    w_ovf_nx    = r_ovf;
    w_rx_we     = 1'b0;
    w_rx_idx    = r_rx_cnt[1:0];
    if (flush) begin
      w_rx_st_nx  = R_EMPTY;
      w_rx_cnt_nx = 3'd0;
      w_ovf_nx    = 1'b0;
    end else begin
      unique case (r_rx_st)
        R_EMPTY, R_FILL: begin
          if (rx_shift_en) begin
            w_rx_we     = 1'b1;
            w_rx_cnt_nx = r_rx_cnt + 3'd1;
            w_rx_st_nx  = (r_rx_cnt == 3'd3) ?
                          R_FULL : R_FILL;
          end
        end
        R_FULL: begin
          // drain and refill in one cycle: new word is slot 0
          if (w_hs) begin
            w_rx_we     = rx_shift_en;
            w_rx_idx    = 2'd0;
            w_rx_cnt_nx = rx_shift_en ? 3'd1 : 3'd0;
            w_rx_st_nx  = rx_shift_en ? R_FILL : R_EMPTY;
          end else if (rx_shift_en) begin
            w_ovf_nx = 1'b1;
          end
        end
        default: begin
          w_rx_st_nx  = R_EMPTY;
          w_rx_cnt_nx = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    w_tx_st_nx  = r_tx_st;
    w_tx_cnt_nx = r_tx_cnt;
    w_udf_nx    = r_udf;
    w_tx_ld     = 1'b0;
    if (flush) begin
      w_tx_st_nx  = T_EMPTY;
      w_tx_cnt_nx = 3'd0;
      w_udf_nx    = 1'b0;
    end else begin
      unique case (r_tx_st)
        T_EMPTY: begin
          if (tx_shift_en)
            w_udf_nx = 1'b1;
          if (res_valid && r_res_ready) begin
            w_tx_ld     = 1'b1;
            w_tx_cnt_nx = 3'd4;
            w_tx_st_nx  = T_DRAIN;
          end
        end
        T_DRAIN: begin
          if (tx_shift_en) begin
            w_tx_cnt_nx = r_tx_cnt - 3'd1;
            if (r_tx_cnt == 3'd1)
              w_tx_st_nx = T_EMPTY;
          end
        end
        default: w_tx_st_nx = T_EMPTY;
      endcase
    end
  end

  always_ff @(posedge hclk or negedge hrst) begin
    if (!hrst) begin
      r_rx_st     <= R_EMPTY;
      r_tx_st     <= T_EMPTY;
      r_rx_cnt    <= 3'd0;
      r_tx_cnt    <= 3'd0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_blk_valid <= 1'b0;
      r_res_ready <= 1'b1;
      r_ahb_mode  <= 1'b0;
      r_ahb_en    <= 1'b1;
    end else begin
      r_rx_st     <= w_rx_st_nx;
      r_tx_st     <= w_tx_st_nx;
      r_rx_cnt    <= w_rx_cnt_nx;
      r_tx_cnt    <= w_tx_cnt_nx;
      r_ovf       <= w_ovf_nx;
      r_udf       <= w_udf_nx;
      r_blk_valid <= (w_rx_st_nx == R_FULL);
      r_res_ready <= (w_tx_st_nx == T_EMPTY);
      r_ahb_mode  <= (w_tx_cnt_nx != 3'd0);
      // write-back wins: stall fetch only when RX is full
      r_ahb_en    <= (w_tx_cnt_nx != 3'd0) ||
                     (w_rx_st_nx != R_FULL);
    end
  end

  // index 4 - cnt, modulo 4
  assign w_rd_idx = ~r_tx_cnt[1:0] + 2'd1;

  aes_word_packer u_rx_pack (
    .hclk      (hclk),
    .hrst      (hrst),
    .i_wr_en   (w_rx_we),
    .i_wr_idx  (w_rx_idx),
    .i_wr_word (w_rx_in),
    .i_ld_en   (1'b0),
    .i_ld_blk  ('0),
    .i_rd_idx  (2'd0),
    .o_rd_word (),
    .o_blk     (blk_data)
  );

  aes_word_packer u_tx_pack (
    .hclk      (hclk),
    .hrst      (hrst),
    .i_wr_en   (1'b0),
    .i_wr_idx  (2'd0),
    .i_wr_word ('0),
    .i_ld_en   (w_tx_ld),
    .i_ld_blk  (res_data),
    .i_rd_idx  (w_rd_idx),
    .o_rd_word (w_tx_raw),
    .o_blk     ()
  );

  assign tx_word    = (r_tx_st == T_DRAIN) ? w_tx_out : '0;
  assign blk_valid  = r_blk_valid;
  assign res_ready  = r_res_ready;
  assign ahb_mode   = r_ahb_mode;
  assign ahb_enable = r_ahb_en;
  assign rx_cnt     = r_rx_cnt;
  assign tx_cnt     = r_tx_cnt;
  assign overflow   = r_ovf;
  assign underflow  = r_udf;

endmodule

// File: tb/tb_aes_block_buffer.sv
// Bench for aes_block_buffer: word/count model plus literal checks.
// Build with AES_BUF_BSWAP_EN to exercise the byte-swap variant.
module tb_aes_block_buffer;

  logic         hclk = 1'b0;
  logic         hrst = 1'b0;
  logic         flush = 1'b0;
  logic [31:0]  rx_word = '0;
  logic         rx_shift_en = 1'b0;
  logic [127:0] blk_data;
  logic         blk_valid;
  logic         blk_ready = 1'b0;
  logic [127:0] res_data = '0;
  logic         res_valid = 1'b0;
  logic         res_ready;
  logic         tx_shift_en = 1'b0;
  logic [31:0]  tx_word;
  logic         ahb_mode, ahb_enable;
  logic [2:0]   rx_cnt, tx_cnt;
  logic         overflow, underflow;

  aes_block_buffer dut (
    .hclk(hclk), .hrst(hrst), .flush(flush),
    .rx_word(rx_word), .rx_shift_en(rx_shift_en),
    .blk_data(blk_data), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .res_data(res_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .tx_shift_en(tx_shift_en), .tx_word(tx_word),
    .ahb_mode(ahb_mode), .ahb_enable(ahb_enable),
    .rx_cnt(rx_cnt), .tx_cnt(tx_cnt),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 hclk = ~hclk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_rx [4];
  logic [31:0] m_tx [4];
  int          m_rxn, m_txn;
  logic        m_ovf, m_udf;

  function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef AES_BUF_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_rx[i] = '0;
      m_tx[i] = '0;
    end
    m_rxn = 0;
    m_txn = 0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic m_step();
    bit was_empty;
    if (flush) begin
      m_rxn = 0;
      m_txn = 0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (m_rxn == 4 && blk_ready)
        m_rxn = 0;
      if (rx_shift_en) begin
        if (m_rxn < 4) begin
          m_rx[m_rxn] = sw(rx_word);
          m_rxn++;
        end else begin
          m_ovf = 1'b1;
        end
      end
      was_empty = (m_txn == 0);
      if (tx_shift_en) begin
        if (was_empty) m_udf = 1'b1;
        else m_txn--;
      end
      if (res_valid && was_empty) begin
        for (int i = 0; i < 4; i++)
          m_tx[i] = res_data[127-32*i -: 32];
        m_txn = 4;
      end
    end
  endtask

  always @(posedge hclk or negedge hrst) begin
    if (!hrst) m_reset();
    else m_step();
  end

  always @(negedge hclk) begin
    if (chk_en) begin
      chk("blk_valid", blk_valid, m_rxn == 4);
      chk("blk_data", blk_data,
          {m_rx[0], m_rx[1], m_rx[2], m_rx[3]});
      chk("res_ready", res_ready, m_txn == 0);
      chk("tx_word", tx_word,
          (m_txn == 0) ? 32'h0 : sw(m_tx[4-m_txn]));
      chk("ahb_mode", ahb_mode, m_txn != 0);
      chk("ahb_enable", ahb_enable,
          (m_txn != 0) || (m_rxn != 4));
      chk("rx_cnt", rx_cnt, m_rxn[2:0]);
      chk("tx_cnt", tx_cnt, m_txn[2:0]);
      chk("overflow", overflow, m_ovf);
      chk("underflow", underflow, m_udf);
    end
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle();
    rx_shift_en = 1'b0;
    blk_ready   = 1'b0;
    res_valid   = 1'b0;
    tx_shift_en = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic push(input logic [31:0] w, input bit rdy);
    rx_shift_en = 1'b1;
    rx_word     = w;
    blk_ready   = rdy;
    tick();
    idle();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    idle();
  endtask

  logic [127:0] l_blk;
  logic [31:0]  l_w0;
  logic [31:0]  l_tx [4];

  initial begin
`ifdef AES_BUF_BSWAP_EN
    l_blk = 128'h33221100_77665544_BBAA9988_FFEEDDCC;
    l_w0  = 32'hEFBEADDE;
`else
    l_blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    l_w0  = 32'hDEADBEEF;
`endif
    l_tx[0] = 32'h01234567;
    l_tx[1] = 32'h89ABCDEF;
    l_tx[2] = 32'hFEDCBA98;
    l_tx[3] = 32'h76543210;

    m_reset();
    #12 hrst = 1'b1;
    chk_en = 1'b1;
    tick();
    chk("rst_res_ready", res_ready, 1'b1);
    chk("rst_enable", ahb_enable, 1'b1);
    chk("rst_rx_cnt", rx_cnt, 3'd0);

    push(32'h00112233, 1'b0);
    push(32'h44556677, 1'b0);
    push(32'h8899AABB, 1'b0);
    push(32'hCCDDEEFF, 1'b0);
    chk("lit_blk_valid", blk_valid, 1'b1);
    chk("lit_blk_data", blk_data, l_blk);
    chk("lit_enable_full", ahb_enable, 1'b0);

    push(32'hDEADBEEF, 1'b0);
    chk("lit_overflow", overflow, 1'b1);
    chk("lit_blk_hold", blk_data, l_blk);

    push(32'hDEADBEEF, 1'b1);
    chk("lit_refill_cnt", rx_cnt, 3'd1);
    chk("lit_refill_w0", blk_data[127:96], l_w0);
    chk("lit_refill_valid", blk_valid, 1'b0);

    do_flush();
    res_valid = 1'b1;
    res_data  = {l_tx[0], l_tx[1], l_tx[2], l_tx[3]};
    tick();
    idle();
    chk("lit_res_ready0", res_ready, 1'b0);
    chk("lit_mode1", ahb_mode, 1'b1);
    chk("lit_tx_cnt4", tx_cnt, 3'd4);
    chk("lit_tx_w0", tx_word, sw(l_tx[0]));
    for (int i = 1; i < 4; i++) begin
      tx_shift_en = 1'b1;
      tick();
      idle();
      chk("lit_tx_seq", tx_word, sw(l_tx[i]));
    end
    tx_shift_en = 1'b1;
    tick();
    idle();
    chk("lit_tx_done_ready", res_ready, 1'b1);
    chk("lit_tx_done_mode", ahb_mode, 1'b0);

    tx_shift_en = 1'b1;
    tick();
    idle();
    chk("lit_underflow", underflow, 1'b1);
    chk("lit_udf_word", tx_word, 32'h0);
    tick();
    chk("lit_udf_sticky", underflow, 1'b1);
    do_flush();
    chk("lit_flush_ovf", overflow, 1'b0);
    chk("lit_flush_udf", underflow, 1'b0);
    chk("lit_flush_rx", rx_cnt, 3'd0);

    push(32'h11111111, 1'b0);
    push(32'h22222222, 1'b0);
    chk("lit_partial", rx_cnt, 3'd2);
    #3 hrst = 1'b0;
    #1;
    chk("lit_arst_cnt", rx_cnt, 3'd0);
    chk("lit_arst_valid", blk_valid, 1'b0);
    #2 hrst = 1'b1;
    tick();
    push(32'hA0A0A0A0, 1'b0);
    push(32'hB1B1B1B1, 1'b0);
    push(32'hC2C2C2C2, 1'b0);
    push(32'hD3D3D3D3, 1'b0);
    chk("lit_fresh_valid", blk_valid, 1'b1);
    chk("lit_fresh_data", blk_data,
        128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3);

`ifdef AES_BUF_BSWAP_EN
    do_flush();
    push(32'h00112233, 1'b0);
    chk("lit_bswap_rx", blk_data[127:96], 32'h33221100);
    res_valid = 1'b1;
    res_data  = {32'h33221100, 96'h0};
    tick();
    idle();
    chk("lit_bswap_tx", tx_word, 32'h00112233);
`endif

    do_flush();
    for (int n = 0; n < 3000; n++) begin
      rx_shift_en = ($urandom % 2) == 0;
      rx_word     = $urandom;
      blk_ready   = ($urandom % 3) == 0;
      res_valid   = ($urandom % 4) == 0;
      res_data    = {$urandom, $urandom, $urandom, $urandom};
      tx_shift_en = ($urandom % 5) < 2;
      flush       = ($urandom % 100) == 0;
      tick();
    end
    idle();
    tick();
    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
